// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial add/subtract using one full adder reused LSB-first
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [WIDTH:0]    result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic fa_a, fa_b, fa_s, fa_c;

  // Operands shift right each RUN cycle so the adder always sees the current bit at [0].
  always_comb begin
    fa_a = a_q[0];
    fa_b = b_q[0];
    fa_s = fa_a ^ fa_b ^ carry_q;
    fa_c = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b here and seed the carry with mode.
          a_d     = a;
          b_d     = b ^ {WIDTH{mode}};
          carry_d = mode;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB, fa_c the carry out of it.
          result_d   = {fa_c, fa_s, sum_q[WIDTH-1:1]};
          overflow_d = carry_q ^ fa_c;
          cnt_d      = '0;
          state_d    = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - randomized self-checking bench for serial_add_sub
module tb_serial_add_sub;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W:0]   result;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] last_res;
  logic       last_ovf;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Unsigned view: carry out plus W-bit sum of a + b or a - b.
  function automatic logic [W:0] ref_result(input logic m, input int x, input int y);
    int r;
    if (!m) r = x + y;
    else    r = x + ((2 ** W) - y);
    return r[W:0];
  endfunction

  // Signed view: overflow when the true signed result leaves the W-bit range.
  function automatic logic ref_ovf(input logic m, input int x, input int y);
    int sx, sy, r;
    sx = (x >= 2 ** (W - 1)) ? x - 2 ** W : x;
    sy = (y >= 2 ** (W - 1)) ? y - 2 ** W : y;
    r  = m ? sx - sy : sx + sy;
    return (r > 2 ** (W - 1) - 1) || (r < -(2 ** (W - 1)));
  endfunction

  // noise: 0 = inputs quiet during RUN, 1 = random inputs incl. start, 2 = start held high
  task automatic issue(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int noise, output logic [W:0] res_o, output logic ovf_o);
    logic [W:0] er;
    logic       eo;
    er = ref_result(m, int'(x), int'(y));
    eo = ref_ovf(m, int'(x), int'(y));
    start = 1'b1; mode = m; a = x; b = y;
    step();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      if (noise == 1) begin
        start = 1'($urandom_range(0, 1));
        mode  = 1'($urandom_range(0, 1));
        a     = W'($urandom);
        b     = W'($urandom);
      end else if (noise == 2) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
      end
      step();
    end
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("result", result, er);
    chk("overflow", overflow, eo);
    res_o    = result;
    ovf_o    = overflow;
    last_res = er;
    last_ovf = eo;
  endtask

  task automatic idle_check();
    start = 1'b0;
    step();
    chk("done_idle", done, 0);
    chk("busy_idle", busy, 0);
    chk("result_hold", result, last_res);
    chk("ovf_hold", overflow, last_ovf);
  endtask

  initial begin
    logic [W:0] r;
    logic       o;

    reset = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", overflow, 0);

    // Reset wins over a simultaneous start.
    start = 1'b1; a = 5'd3; b = 5'd4;
    step();
    chk("rst_prio_busy", busy, 0);
    reset = 1'b0; start = 1'b0;
    step();
    chk("rst_prio_idle", busy, 0);
    last_res = '0; last_ovf = 1'b0;

    issue(1'b0, 5'b11111, 5'b11111, 0, r, o);
    chk("add_max_res", r, 6'b111110);
    chk("add_max_ovf", o, 0);
    idle_check();

    issue(1'b0, 5'b01111, 5'b00001, 0, r, o);
    chk("add_ovf_res", r, 6'b010000);
    chk("add_ovf_ovf", o, 1);
    idle_check();

    issue(1'b1, 5'b00011, 5'b00101, 0, r, o);
    chk("sub_neg_res", r, 6'b011110);
    chk("sub_neg_ovf", o, 0);
    idle_check();

    issue(1'b1, 5'b00101, 5'b00011, 0, r, o);
    chk("sub_pos_res", r, 6'b100010);
    chk("sub_pos_ovf", o, 0);
    idle_check();

    // Restart attempts and operand changes while running must be ignored.
    issue(1'b0, 5'd10, 5'd7, 1, r, o);
    chk("ignore_res", r, 6'd17);
    idle_check();

    // start held high: back-to-back operations, done every W+1 cycles.
    issue(1'b0, 5'd9, 5'd12, 2, r, o);
    issue(1'b1, 5'd2, 5'd30, 2, r, o);
    issue(1'b1, 5'd16, 5'd1, 2, r, o);
    chk("b2b_last_ovf", o, 1);
    idle_check();

    // Reset during the third RUN cycle aborts the operation.
    start = 1'b1; mode = 1'b0; a = 5'd6; b = 5'd7;
    step();
    start = 1'b0;
    step();
    step();
    chk("abort_busy_pre", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_ovf", overflow, 0);
    last_res = '0; last_ovf = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      step();
      chk("abort_no_done", done, 0);
    end

    for (int n = 0; n < 60; n++) begin
      issue(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
            int'($urandom_range(0, 1)), r, o);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising edge of clk.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation; sampled on rising edge of clk.
REQ-005 The block SHALL have port mode, input, 1, operation select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 The block SHALL have port a, input, WIDTH, first operand; sampled with start.
REQ-007 The block SHALL have port b, input, WIDTH, second operand; sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1, single-cycle pulse marking result valid.
REQ-010 The block SHALL have port result, output, WIDTH+1, {carry_out, sum[WIDTH-1:0]}.
REQ-011 The block SHALL have port overflow, output, 1, two's-complement signed overflow of the last operation.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE, with exactly one full-adder datapath reused one bit per cycle.
REQ-013 In IDLE or DONE, start=1 SHALL latch a, b XOR {WIDTH{mode}}, carry register <= mode, bit counter <= 0, and move to RUN.
REQ-014 In RUN, each cycle SHALL add bit i of both latched operands plus the carry register, store sum bit i, update the carry register, and increment the counter.
REQ-015 When bit WIDTH-1 is processed, the FSM SHALL move RUN->DONE.
REQ-016 The FSM SHALL move DONE->IDLE after one cycle unless start=1 (see REQ-013).
REQ-017 Latency: for start sampled at edge k, done SHALL be high for exactly the cycle following edge k+WIDTH.
REQ-018 busy SHALL be high exactly while in RUN, i.e. WIDTH cycles per operation.
REQ-019 result SHALL update only on the RUN->DONE edge and hold its value until the next completion or reset.
REQ-020 result[WIDTH] SHALL be the final carry out; for subtraction, 1 means a>=b unsigned.
REQ-021 overflow SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; it updates and holds together with result.
REQ-022 start while in RUN SHALL be ignored, with no effect on latched operands, mode or timing.
REQ-023 start in the DONE cycle SHALL be accepted, giving back-to-back operations with no IDLE gap.
REQ-024 Changes on a, b or mode after the start edge SHALL NOT affect the operation in progress.

Reset
REQ-025 reset=1 SHALL force state IDLE, busy=0, done=0, result=0, overflow=0, counter=0, carry register=0.
REQ-026 reset SHALL take priority over start in the same cycle.
REQ-027 reset asserted mid-RUN SHALL abort the operation, with no done pulse and result=0.

Verification (WIDTH=5)
REQ-028 Scenario: add 11111+11111 -> after 5 cycles, done=1, result=111110, overflow=0.
REQ-029 Scenario: add 01111+00001 -> result=010000, overflow=1.
REQ-030 Scenario: sub 00011-00101 -> result=011110 (carry 0, sum -2), overflow=0; sub 00101-00011 -> result=100010, overflow=0.
REQ-031 Scenario: start pulsed again during RUN with different operands -> ignored; first result delivered at the original cycle.
REQ-032 Scenario: reset asserted at the third RUN cycle -> no done pulse, result=000000, busy=0 on the next cycle.
REQ-033 Scenario: start held high continuously over 3 operations -> done pulses every 6 cycles, busy low only in DONE cycles, each result correct.
